// File: rtl/cdb_arbiter.sv
// CDB transmit arbiter: per-unit FIFOs feed a round-robin grant; strobe 2 edges after accept, one pulse per 2 cycles.
// Backpressure via registered per-unit ready (!full). Optional `CDB_HOLD_EN adds in_CDB_hold to freeze grants.

module cdb_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdat,
  output logic [W-1:0] rdat,
  output logic         empty,
  output logic         rdy
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          rdy_q, rdy_d;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + (AW+1)'(1);
    else if (pop && !push) cnt_d = cnt_q - (AW+1)'(1);
    // ready reflects the post-edge occupancy so a full FIFO stays closed while it drains
    rdy_d    = (cnt_d != (AW+1)'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      rdy_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      rdy_q    <= rdy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdat;
  end

  assign rdat  = mem_q[rd_ptr_q];
  assign empty = (cnt_q == '0);
  assign rdy   = rdy_q;
endmodule

module cdb_arbiter #(
  parameter int               NUM_UNITS   = 4,
  parameter int               TAG_W       = 5,
  parameter int               DATA_W      = 32,
  parameter int               FIFO_DEPTH  = 2,
  parameter logic [TAG_W-1:0] INVALID_TAG = {TAG_W{1'b1}}
) (
  input  logic                        clk,
  input  logic                        rst,
`ifdef CDB_HOLD_EN
  input  logic                        in_CDB_hold,
`endif
  input  logic [NUM_UNITS-1:0]        in_unit_valid,
  input  logic [NUM_UNITS*TAG_W-1:0]  in_unit_tag,
  input  logic [NUM_UNITS*DATA_W-1:0] in_unit_val,
  output logic [NUM_UNITS-1:0]        out_unit_ready,
  output logic                        out_CDB_broadcast,
  output logic [TAG_W-1:0]            out_CDB_tag,
  output logic [DATA_W-1:0]           out_CDB_val,
  output logic [7:0]                  out_drop_cnt
);
  localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] val;
  } cdb_ent_t;

  typedef enum logic {ARB, BCAST} state_t;

  cdb_ent_t             unit_ent [NUM_UNITS];
  cdb_ent_t             head_ent [NUM_UNITS];
  logic [NUM_UNITS-1:0] push, pop, empty, drop;
  logic                 hold;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d, grant_idx, cand;
  logic                 grant_vld, grant_fire;
  logic                 bcast_q, bcast_d;
  logic [TAG_W-1:0]     tag_q, tag_d;
  logic [DATA_W-1:0]    val_q, val_d;
  logic [7:0]           drop_cnt_q, drop_cnt_d;
  int                   idx;

`ifdef CDB_HOLD_EN
  assign hold = in_CDB_hold;
`else
  assign hold = 1'b0;
`endif

  for (genvar i = 0; i < NUM_UNITS; i++) begin : g_unit
    assign unit_ent[i] = {in_unit_tag[i*TAG_W +: TAG_W], in_unit_val[i*DATA_W +: DATA_W]};
    assign drop[i]     = in_unit_valid[i] & out_unit_ready[i] & (unit_ent[i].tag == INVALID_TAG);
    assign push[i]     = in_unit_valid[i] & out_unit_ready[i] & (unit_ent[i].tag != INVALID_TAG);
    assign pop[i]      = grant_fire & (grant_idx == PTR_W'(i));

    cdb_fifo #(
      .W     ($bits(cdb_ent_t)),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[i]),
      .pop   (pop[i]),
      .wdat  (unit_ent[i]),
      .rdat  (head_ent[i]),
      .empty (empty[i]),
      .rdy   (out_unit_ready[i])
    );
  end

  // Search starts just after the last granted unit; occupancy is pre-edge, so no bypass.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    idx       = 0;
    for (int off = 1; off <= NUM_UNITS; off++) begin
      idx = int'(ptr_q) + off;
      if (idx >= NUM_UNITS) idx = idx - NUM_UNITS;
      cand = PTR_W'(idx);
      if (!grant_vld && !empty[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign grant_fire = (state_q == ARB) && !hold && grant_vld;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    bcast_d    = 1'b0;
    tag_d      = tag_q;
    val_d      = val_q;
    drop_cnt_d = drop_cnt_q;
    case (state_q)
      ARB: begin
        if (grant_fire) begin
          state_d = BCAST;
          ptr_d   = grant_idx;
          bcast_d = 1'b1;
          tag_d   = head_ent[grant_idx].tag;
          val_d   = head_ent[grant_idx].val;
        end
      end
      BCAST:   state_d = ARB;
      default: state_d = ARB;
    endcase
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (drop[i] && drop_cnt_d != 8'hFF) drop_cnt_d = drop_cnt_d + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB;
      ptr_q      <= PTR_W'(NUM_UNITS - 1);
      bcast_q    <= 1'b0;
      tag_q      <= INVALID_TAG;
      val_q      <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      bcast_q    <= bcast_d;
      tag_q      <= tag_d;
      val_q      <= val_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign out_CDB_broadcast = bcast_q;
  assign out_CDB_tag       = tag_q;
  assign out_CDB_val       = val_q;
  assign out_drop_cnt      = drop_cnt_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: vector table, directed corner sequences, and a queue-based random reference model.
// Build with +define+CDB_HOLD_EN to include the hold sequence.

module tb_cdb_arbiter;
  localparam int         NU    = 4;
  localparam int         TW    = 5;
  localparam int         DW    = 32;
  localparam int         DEPTH = 2;
  localparam logic [4:0] INV   = 5'd31;

  logic             clk = 1'b0;
  logic             rst;
  logic [NU-1:0]    in_unit_valid;
  logic [NU*TW-1:0] in_unit_tag;
  logic [NU*DW-1:0] in_unit_val;
  logic [NU-1:0]    out_unit_ready;
  logic             out_CDB_broadcast;
  logic [TW-1:0]    out_CDB_tag;
  logic [DW-1:0]    out_CDB_val;
  logic [7:0]       out_drop_cnt;
`ifdef CDB_HOLD_EN
  logic             hold;
`endif

  cdb_arbiter #(
    .NUM_UNITS(NU), .TAG_W(TW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .INVALID_TAG(INV)
  ) dut (
    .clk               (clk),
    .rst               (rst),
`ifdef CDB_HOLD_EN
    .in_CDB_hold       (hold),
`endif
    .in_unit_valid     (in_unit_valid),
    .in_unit_tag       (in_unit_tag),
    .in_unit_val       (in_unit_val),
    .out_unit_ready    (out_unit_ready),
    .out_CDB_broadcast (out_CDB_broadcast),
    .out_CDB_tag       (out_CDB_tag),
    .out_CDB_val       (out_CDB_val),
    .out_drop_cnt      (out_drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         unit;
    logic [4:0] tag;
    logic [31:0] val;
    bit         exp_bcast;
    logic [7:0] exp_drop;
  } vec_t;

  typedef struct {
    logic [4:0]  tag;
    logic [31:0] val;
  } ent_t;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_unit(input int u, input logic v, input logic [4:0] t, input logic [31:0] d);
    in_unit_valid[u]         = v;
    in_unit_tag[u*TW +: TW]  = t;
    in_unit_val[u*DW +: DW]  = d;
  endtask

  task automatic idle();
    in_unit_valid = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic run_vectors();
    vec_t       vt [8];
    logic [4:0] last_tag = INV;
    logic [31:0] last_val = 32'd0;
    vt[0] = '{2, 5'd5,  32'h0000002A, 1'b1, 8'd0};
    vt[1] = '{0, 5'd7,  32'hDEADBEEF, 1'b1, 8'd0};
    vt[2] = '{3, 5'd0,  32'h00000001, 1'b1, 8'd0};
    vt[3] = '{1, 5'd30, 32'hFFFFFFFF, 1'b1, 8'd0};
    vt[4] = '{0, 5'd31, 32'h00000123, 1'b0, 8'd1};
    vt[5] = '{3, 5'd31, 32'h00000005, 1'b0, 8'd2};
    vt[6] = '{2, 5'd17, 32'h00000000, 1'b1, 8'd2};
    vt[7] = '{1, 5'd31, 32'h00000000, 1'b0, 8'd3};
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("vec%0d ready", i), 64'(out_unit_ready[vt[i].unit]), 64'(1));
      set_unit(vt[i].unit, 1'b1, vt[i].tag, vt[i].val);
      tick();
      idle();
      tick();
      chk($sformatf("vec%0d strobe", i), 64'(out_CDB_broadcast), 64'(vt[i].exp_bcast));
      if (vt[i].exp_bcast) begin
        last_tag = vt[i].tag;
        last_val = vt[i].val;
        chk($sformatf("vec%0d tag", i), 64'(out_CDB_tag), 64'(last_tag));
        chk($sformatf("vec%0d val", i), 64'(out_CDB_val), 64'(last_val));
      end
      tick();
      chk($sformatf("vec%0d strobe_low", i), 64'(out_CDB_broadcast), 64'(0));
      chk($sformatf("vec%0d tag_hold", i), 64'(out_CDB_tag), 64'(last_tag));
      chk($sformatf("vec%0d val_hold", i), 64'(out_CDB_val), 64'(last_val));
      chk($sformatf("vec%0d drop", i), 64'(out_drop_cnt), 64'(vt[i].exp_drop));
    end
  endtask

  task automatic run_all_units();
    do_reset();
    for (int u = 0; u < NU; u++) set_unit(u, 1'b1, 5'(u + 1), 32'(100 + u));
    tick();
    idle();
    for (int k = 0; k < NU; k++) begin
      tick();
      chk($sformatf("rr%0d strobe", k), 64'(out_CDB_broadcast), 64'(1));
      chk($sformatf("rr%0d tag", k), 64'(out_CDB_tag), 64'(k + 1));
      chk($sformatf("rr%0d val", k), 64'(out_CDB_val), 64'(100 + k));
      tick();
      chk($sformatf("rr%0d gap", k), 64'(out_CDB_broadcast), 64'(0));
    end
    set_unit(3, 1'b1, 5'd9, 32'h333);
    set_unit(1, 1'b1, 5'd10, 32'h111);
    tick();
    idle();
    tick();
    chk("refill first tag", 64'(out_CDB_tag), 64'(10));
    tick();
    tick();
    chk("refill second strobe", 64'(out_CDB_broadcast), 64'(1));
    chk("refill second tag", 64'(out_CDB_tag), 64'(9));
  endtask

  task automatic run_backpressure();
    int sent = 0, got = 0, ready_low = 0, double_hi = 0;
    bit acc, prev = 1'b0;
    do_reset();
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (sent < 4) set_unit(1, 1'b1, 5'(6 + sent), 32'(32'h600 + sent));
      else idle();
      acc = (sent < 4) && out_unit_ready[1];
      if (!out_unit_ready[1]) ready_low++;
      tick();
      if (acc) sent++;
      if (out_CDB_broadcast) begin
        chk($sformatf("bp order %0d", got), 64'(out_CDB_tag), 64'(6 + got));
        got++;
        if (prev) double_hi++;
      end
      prev = out_CDB_broadcast;
    end
    idle();
    chk("bp accepted", 64'(sent), 64'(4));
    chk("bp broadcast", 64'(got), 64'(4));
    chk("bp ready_low_seen", 64'(ready_low > 0), 64'(1));
    chk("bp pulse_width", 64'(double_hi), 64'(0));
  endtask

  task automatic run_drops();
    int strobes = 0;
    do_reset();
    set_unit(0, 1'b1, INV, 32'h1);
    tick();
    idle();
    chk("drop single", 64'(out_drop_cnt), 64'(1));
    for (int i = 0; i < 4; i++) begin
      tick();
      if (out_CDB_broadcast) strobes++;
    end
    chk("drop no strobe", 64'(strobes), 64'(0));
    for (int u = 0; u < NU; u++) set_unit(u, 1'b1, INV, 32'h0);
    tick();
    idle();
    chk("drop multi", 64'(out_drop_cnt), 64'(5));
    set_unit(0, 1'b1, INV, 32'h2);
    for (int i = 0; i < 300; i++) tick();
    idle();
    tick();
    chk("drop saturate", 64'(out_drop_cnt), 64'(255));
    for (int u = 0; u < NU; u++) set_unit(u, 1'b1, INV, 32'h0);
    tick();
    idle();
    chk("drop saturate multi", 64'(out_drop_cnt), 64'(255));
  endtask

  task automatic run_mid_reset();
    int strobes = 0;
    do_reset();
    for (int u = 0; u < 3; u++) set_unit(u, 1'b1, 5'(11 + u), 32'(32'hA0 + u));
    tick();
    idle();
    tick();
    chk("mr pre strobe", 64'(out_CDB_broadcast), 64'(1));
    rst = 1'b1;
    tick();
    chk("mr strobe", 64'(out_CDB_broadcast), 64'(0));
    chk("mr tag", 64'(out_CDB_tag), 64'(INV));
    chk("mr val", 64'(out_CDB_val), 64'(0));
    chk("mr ready", 64'(out_unit_ready), 64'(0));
    rst = 1'b0;
    tick();
    chk("mr ready_back", 64'(out_unit_ready), 64'(4'hF));
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_CDB_broadcast) strobes++;
    end
    chk("mr no broadcast", 64'(strobes), 64'(0));
  endtask

`ifdef CDB_HOLD_EN
  task automatic run_hold();
    int strobes = 0;
    do_reset();
    hold = 1'b1;
    set_unit(0, 1'b1, 5'd14, 32'hE);
    set_unit(2, 1'b1, 5'd15, 32'hF);
    tick();
    idle();
    for (int i = 0; i < 5; i++) begin
      tick();
      if (out_CDB_broadcast) strobes++;
    end
    chk("hold no strobe", 64'(strobes), 64'(0));
    chk("hold tag frozen", 64'(out_CDB_tag), 64'(INV));
    hold = 1'b0;
    tick();
    chk("hold release strobe", 64'(out_CDB_broadcast), 64'(1));
    chk("hold release tag", 64'(out_CDB_tag), 64'(14));
    hold = 1'b1;
    tick();
    chk("hold in bcast pulse", 64'(out_CDB_broadcast), 64'(0));
    tick();
    chk("hold frozen again", 64'(out_CDB_broadcast), 64'(0));
    hold = 1'b0;
    tick();
    chk("hold second strobe", 64'(out_CDB_broadcast), 64'(1));
    chk("hold second tag", 64'(out_CDB_tag), 64'(15));
  endtask
`endif

  // Reference model: per-unit queues, a "last served" index and a cool-down after each pulse.
  task automatic run_random();
    ent_t          mq [NU][$];
    ent_t          e;
    int            m_last = NU - 1;
    bit            m_bc = 1'b0, nb;
    logic [4:0]    m_tag = INV;
    logic [31:0]   m_val = 32'd0;
    int            m_drop = 0, u, pct;
    logic [NU-1:0] v_now, rdy_now;
    logic [4:0]    t_now [NU];
    logic [31:0]   d_now [NU];
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      chk("rnd strobe", 64'(out_CDB_broadcast), 64'(m_bc));
      chk("rnd tag", 64'(out_CDB_tag), 64'(m_tag));
      chk("rnd val", 64'(out_CDB_val), 64'(m_val));
      chk("rnd drop", 64'(out_drop_cnt), 64'(m_drop));
      for (int k = 0; k < NU; k++) begin
        rdy_now[k] = (mq[k].size() < DEPTH);
        chk($sformatf("rnd ready%0d", k), 64'(out_unit_ready[k]), 64'(rdy_now[k]));
      end
      pct = (cyc < 750) ? 25 : 80;
      for (int k = 0; k < NU; k++) begin
        v_now[k] = ($urandom_range(0, 99) < pct);
        t_now[k] = ($urandom_range(0, 7) == 0) ? INV : 5'($urandom_range(0, 30));
        d_now[k] = $urandom;
        set_unit(k, v_now[k], t_now[k], d_now[k]);
      end
      nb = 1'b0;
      if (!m_bc) begin
        for (int k = 1; k <= NU; k++) begin
          u = (m_last + k) % NU;
          if (!nb && mq[u].size() > 0) begin
            nb     = 1'b1;
            m_last = u;
            m_tag  = mq[u][0].tag;
            m_val  = mq[u][0].val;
            void'(mq[u].pop_front());
          end
        end
      end
      for (int k = 0; k < NU; k++) begin
        if (v_now[k] && rdy_now[k]) begin
          if (t_now[k] == INV) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
          else begin
            e.tag = t_now[k];
            e.val = d_now[k];
            mq[k].push_back(e);
          end
        end
      end
      m_bc = nb;
      tick();
    end
    idle();
  endtask

  initial begin
`ifdef CDB_HOLD_EN
    hold = 1'b0;
`endif
    in_unit_valid = '0;
    in_unit_tag   = '0;
    in_unit_val   = '0;
    rst = 1'b1;
    tick();
    chk("reset ready", 64'(out_unit_ready), 64'(0));
    chk("reset strobe", 64'(out_CDB_broadcast), 64'(0));
    chk("reset tag", 64'(out_CDB_tag), 64'(INV));
    chk("reset val", 64'(out_CDB_val), 64'(0));
    chk("reset drop", 64'(out_drop_cnt), 64'(0));
    tick();
    rst = 1'b0;
    tick();
    chk("ready after reset", 64'(out_unit_ready), 64'(4'hF));
    run_vectors();
    run_all_units();
    run_backpressure();
    run_drops();
    run_mid_reset();
`ifdef CDB_HOLD_EN
    run_hold();
`endif
    run_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
